booth_mul_arbiter: RTL and testbench

- Sequential radix-2 Booth multiplier shared between two requesters.
- Round-robin arbitration selects one request at a time.
- The block runs one Booth step per clock and returns the signed product tagged with the requester id.
- Sits between the arithmetic clients and the multiplier datapath, replacing per-client combinational multipliers.

---
 rtl/booth_mul_arbiter.sv | 177 +++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: radix-2 Booth multiplier shared by two requesters.
// Round-robin arbitration picks one request at a time. The block runs one
// Booth step per clock and returns the signed product tagged with the
// requester id.
//
// Optional feature macro: BOOTH_MUL_ARB_ZERO_SKIP_EN
//   When defined, a request with a zero operand skips the Booth steps and
//   completes one cycle after acceptance with rsp_z = 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0_valid/ready    requester 0 handshake (ready is combinational)
//   req0_x, req0_y      requester 0 operands (signed multiplier, multiplicand)
//   req1_valid/ready    requester 1 handshake (ready is combinational)
//   req1_x, req1_y      requester 1 operands
//   rsp_valid/ready     product handshake
//   rsp_id              requester that issued the product
//   rsp_z               signed 2*WIDTH product
//   busy                high whenever the block is not idle
module booth_mul_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_x,
  input  logic [WIDTH-1:0]   req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_x,
  input  logic [WIDTH-1:0]   req1_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_z,
  output logic               busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             e;

  logic             grant1_c;
  logic             accept_c;
  logic [WIDTH-1:0] sel_x_c;
  logic [WIDTH-1:0] sel_y_c;
  logic             zero_c;
  logic             step_done_c;
  logic             xbit_c;
  logic [WIDTH:0]   y_ext_c;
  logic [WIDTH:0]   sum_c;

  // Arbitration, handshake and next-state decode.
  always_comb begin
    grant1_c    = 1'b0;
    accept_c    = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    sel_x_c     = req0_x;
    sel_y_c     = req0_y;
    zero_c      = 1'b0;
    step_done_c = (cnt == CNT_W'(WIDTH));
    state_nxt   = state;

    // req1 wins when it is alone, or on a tie when req0 was served last.
    grant1_c   = req1_valid & (~req0_valid | ~last);
    accept_c   = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = (state == IDLE) & req0_valid & ~grant1_c;
    req1_ready = (state == IDLE) & grant1_c;
    if (grant1_c) begin
      sel_x_c = req1_x;
      sel_y_c = req1_y;
    end

`ifdef BOOTH_MUL_ARB_ZERO_SKIP_EN
    zero_c = (sel_x_c == '0) | (sel_y_c == '0);
`else
    zero_c = 1'b0;
`endif

    case (state)
      IDLE: if (accept_c)    state_nxt = BUSY;
      BUSY: if (step_done_c) state_nxt = DONE;
      DONE: if (rsp_ready)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // One Booth step: add/subtract sign-extended y on WIDTH+1 bits so the
  // most negative multiplicand needs no fixup.
  always_comb begin
    xbit_c  = 1'b0;
    y_ext_c = {y_r[WIDTH-1], y_r};
    sum_c   = acc_hi;
    if (!step_done_c) begin
      xbit_c = x_r[cnt[IDX_W-1:0]];
    end
    case ({xbit_c, e})
      2'b10:   sum_c = acc_hi - y_ext_c;
      2'b01:   sum_c = acc_hi + y_ext_c;
      default: sum_c = acc_hi;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      cnt       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      e         <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_z     <= '0;
      busy      <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      rsp_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            x_r    <= sel_x_c;
            y_r    <= sel_y_c;
            rsp_id <= grant1_c;
            last   <= grant1_c;
            acc_hi <= '0;
            acc_lo <= '0;
            e      <= 1'b0;
            // A zero operand starts with the counter exhausted, so the
            // cleared accumulator is published on the next edge.
            cnt    <= zero_c ? CNT_W'(WIDTH) : '0;
          end
        end
        BUSY: begin
          if (step_done_c) begin
            rsp_z <= PW'({acc_hi[WIDTH-1:0], acc_lo});
          end else begin
            acc_hi <= {sum_c[WIDTH], sum_c[WIDTH:1]};
            acc_lo <= {sum_c[0], acc_lo[WIDTH-1:1]};
            e      <= xbit_c;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter (WIDTH=4).
module tb_booth_mul_arbiter;

  localparam int unsigned W   = 4;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned LAT = W + 1;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready;
  logic [W-1:0]  req0_x, req0_y;
  logic          req1_valid, req1_ready;
  logic [W-1:0]  req1_x, req1_y;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [PW-1:0] rsp_z;

  booth_mul_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=idle, 1=computing, 2=holding a product.
  int                  m_st;
  int                  m_wait;
  logic                m_last;
  logic                m_id;
  logic [PW-1:0]       m_z;
  logic                m_g1c;
  logic signed [W-1:0] m_ax, m_by;
  logic [PW-1:0]       m_prod;
  logic                m_zero;

  always_comb begin
    m_g1c  = req1_valid && (!req0_valid || (m_last == 1'b0));
    m_ax   = m_g1c ? req1_x : req0_x;
    m_by   = m_g1c ? req1_y : req0_y;
    m_prod = PW'(int'(m_ax) * int'(m_by));
`ifdef BOOTH_MUL_ARB_ZERO_SKIP_EN
    m_zero = (m_ax == 0) || (m_by == 0);
`else
    m_zero = 1'b0;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st   <= 0;
      m_wait <= 0;
      m_last <= 1'b1;
      m_id   <= 1'b0;
      m_z    <= '0;
    end else begin
      case (m_st)
        0: if (req0_valid || req1_valid) begin
          m_id   <= m_g1c;
          m_last <= m_g1c;
          m_z    <= m_zero ? '0 : m_prod;
          m_wait <= m_zero ? 1 : LAT;
          m_st   <= 1;
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_st <= 2;
        end
        default: if (rsp_ready) m_st <= 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("req0_ready", 32'(req0_ready), 32'((m_st == 0) && req0_valid && !m_g1c));
      check("req1_ready", 32'(req1_ready), 32'((m_st == 0) && m_g1c));
      check("rsp_valid",  32'(rsp_valid),  32'(m_st == 2));
      check("busy",       32'(busy),       32'(m_st != 0));
      if (m_st == 2) begin
        check("rsp_z",  32'(rsp_z),  32'(m_z));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input logic id, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
      if (seen) break;
    end
    check({name, "_accept"}, 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = rsp_valid;
      if (seen) break;
    end
    check({name, "_rsp_seen"}, 32'(seen), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic run_one(input logic id, input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                         input logic [PW-1:0] exp_z, input string name);
    int lat;
    int exp_lat;
    exp_lat = LAT;
`ifdef BOOTH_MUL_ARB_ZERO_SKIP_EN
    if (x == 0 || y == 0) exp_lat = 1;
`endif
    tick();
    if (id) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else    begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    wait_ready(id, name);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Scramble operands after acceptance; they must have no effect.
    req0_x = ~x; req0_y = ~y; req1_x = ~x; req1_y = ~y;
    wait_rsp(name, lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_z"},   32'(rsp_z), 32'(exp_z));
    check({name, "_id"},  32'(rsp_id), 32'(id));
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] v;
    logic signed [W-1:0] sx, sy;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    check("reset_rsp_z",     32'(rsp_z),     32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single request and corner operands.
    run_one(1'b0, 4'sd3, -4'sd2, 8'hFA, "single");
    run_one(1'b1, 4'sh8, 4'sh8, 8'h40, "m8m8");
    run_one(1'b1, 4'sd7, 4'sh8, 8'hC8, "p7m8");
    run_one(1'b1, 4'sh8, 4'sd7, 8'hC8, "m8p7");

    // Both requesters held valid: service alternates 0,1,0,1.
    tick();
    req0_valid = 1'b1; req0_x = 4'sd2;  req0_y = 4'sd3;
    req1_valid = 1'b1; req1_x = -4'sd1; req1_y = 4'sd5;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("tie", lat);
      check("tie_id", 32'(rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      check("tie_z",  32'(rsp_z),  (k % 2 == 0) ? 32'h06 : 32'hFB);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // Backpressure: DONE held for 10 cycles while both requesters wait.
    tick();
    req0_valid = 1'b1; req0_x = 4'sd5; req0_y = -4'sd3;
    wait_ready(1'b0, "bp");
    req1_valid = 1'b1; req1_x = 4'sd1; req1_y = 4'sd1;
    wait_rsp("bp", lat);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_z",     32'(rsp_z),     32'hF1);
      check("bp_id",    32'(rsp_id),    32'd0);
      check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("bp_consumed", 32'(rsp_valid), 32'd0);

    // Reset two cycles into a computation.
    tick();
    req1_valid = 1'b1; req1_x = 4'sd6; req1_y = 4'sd5;
    wait_ready(1'b1, "rst");
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_z",     32'(rsp_z),     32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("rst_no_stale", 32'({rsp_valid, busy}), 32'd0);
    end
    run_one(1'b1, 4'sd6, 4'sd5, 8'h1E, "after_rst");

    // Exhaustive sweep, alternating requesters.
    for (int i = 0; i < 256; i++) begin
      v  = 8'(i);
      sx = v[7:4];
      sy = v[3:0];
      run_one(v[0], sx, sy, PW'(int'(sx) * int'(sy)), "sweep");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
